// File: rtl/fb_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module : fb_mdu_pkg
// Purpose: Shared types and constants for the fb_mdu multiply/divide unit.
//          It holds the funct3 op codes FB_MDU_MUL..FB_MDU_REMU, the FSM
//          state encodings FB_MDU_IDLE/CALC/FIX/DONE and the datapath width.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package fb_mdu_pkg;

  // Operand/result width. Only 32 is supported.
  localparam int MDU_XLEN  = 32;
  // Iteration count. This must equal MDU_XLEN.
  localparam int MDU_STEPS = 32;
  localparam int MDU_CNT_W = 5;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    FB_MDU_MUL    = 3'd0,
    FB_MDU_MULH   = 3'd1,
    FB_MDU_MULHSU = 3'd2,
    FB_MDU_MULHU  = 3'd3,
    FB_MDU_DIV    = 3'd4,
    FB_MDU_DIVU   = 3'd5,
    FB_MDU_REM    = 3'd6,
    FB_MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    FB_MDU_IDLE = 2'd0,
    FB_MDU_CALC = 2'd1,
    FB_MDU_FIX  = 2'd2,
    FB_MDU_DONE = 2'd3
  } mdu_state_e;

  // Two's-complement negate when en is set. 0x80000000 maps to itself, and
  // that value is still the correct unsigned magnitude.
  function automatic logic [MDU_XLEN-1:0] neg_if(input logic en,
                                                 input logic [MDU_XLEN-1:0] v);
    return en ? (~v + {{(MDU_XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_mdu_if.sv
`default_nettype none
// ============================================================================
// Module : fb_mdu_if
// Purpose: Request/response handshake bundle between the execute stage and
//          fb_mdu.
// Ports  : req_valid/req_ready/req_op/op1/op2 form the request channel.
//          resp_valid/resp_ready/resp_data form the response channel.
//          The master modport is the requester. The slave modport is the unit.
// Rev    : 1.0  initial release
// ============================================================================
interface fb_mdu_if;
  import fb_mdu_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [2:0]          req_op;
  logic [MDU_XLEN-1:0] op1;
  logic [MDU_XLEN-1:0] op2;
  logic                resp_valid;
  logic                resp_ready;
  logic [MDU_XLEN-1:0] resp_data;

  modport master (
    output req_valid, req_op, op1, op2, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, op1, op2, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface
`default_nettype wire

// File: rtl/fb_mdu_step.sv
`default_nettype none
// ============================================================================
// Module : fb_mdu_step
// Purpose: One combinational iteration of the multiply/divide engine.
//          Multiply: unsigned shift-add. acc = {partial hi, multiplier/lo}.
//          Divide  : restoring shift-subtract. acc[31:0] shifts the dividend
//                    out and the quotient in. rem is the partial remainder.
// Ports  : is_div  - 1 selects divide, 0 selects multiply
//          acc     - 64-bit accumulator
//          rem     - partial remainder
//          opnd    - multiplicand (mul) or divisor (div) magnitude
//          acc_nxt - next accumulator, which carries the quotient for divide
//          rem_nxt - next partial remainder
// Rev    : 1.0  initial release
// ============================================================================
module fb_mdu_step
  import fb_mdu_pkg::*;
(
  input  logic                  is_div,
  input  logic [2*MDU_XLEN-1:0] acc,
  input  logic [MDU_XLEN-1:0]   rem,
  input  logic [MDU_XLEN-1:0]   opnd,
  output logic [2*MDU_XLEN-1:0] acc_nxt,
  output logic [MDU_XLEN-1:0]   rem_nxt
);

  logic [MDU_XLEN:0] sum;
  logic [MDU_XLEN:0] shifted;
  logic [MDU_XLEN:0] diff;
  logic              ge;

  always_comb begin
    acc_nxt = acc;
    rem_nxt = rem;

    // Multiply: add the multiplicand into the high half when the current
    // multiplier bit is set. Then shift the 65-bit result right by one.
    sum = {1'b0, acc[2*MDU_XLEN-1:MDU_XLEN]} +
          (acc[0] ? {1'b0, opnd} : {(MDU_XLEN+1){1'b0}});

    // Divide: this is the 33-bit partial remainder after bringing in the
    // next dividend bit. If shifted[32] is set, shifted is already at least
    // the divisor. Otherwise diff[32] is the borrow from the subtraction.
    shifted = {rem, acc[MDU_XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    ge      = shifted[MDU_XLEN] | ~diff[MDU_XLEN];

    if (is_div) begin
      rem_nxt = ge ? diff[MDU_XLEN-1:0] : shifted[MDU_XLEN-1:0];
      acc_nxt = {acc[2*MDU_XLEN-1:MDU_XLEN], acc[MDU_XLEN-2:0], ge};
    end else begin
      acc_nxt = {sum, acc[MDU_XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_mdu.sv
`default_nettype none
// ============================================================================
// Module : fb_mdu
// Purpose: Multi-cycle RV32M multiply/divide responder. It iterates 32 steps
//          on the operand magnitudes and then applies the sign fix-up in one
//          FIX cycle. Divide-by-zero and signed overflow skip straight to FIX.
// Ports  : clk    - rising-edge clock
//          rst_n  - asynchronous active-low reset
//          flush  - abort to IDLE (present only with FB_MDU_FLUSH_EN)
//          bus    - fb_mdu_if.slave request/response handshake
//          busy   - unit is not in IDLE
// Config : `define FB_MDU_FLUSH_EN adds the flush port.
// Rev    : 1.0  initial release
// ============================================================================
module fb_mdu
  import fb_mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int STEPS = MDU_STEPS
) (
  input  logic     clk,
  input  logic     rst_n,
`ifdef FB_MDU_FLUSH_EN
  input  logic     flush,
`endif
  fb_mdu_if.slave  bus,
  output logic     busy
);

  mdu_state_e              state, state_nxt;
  logic [MDU_CNT_W-1:0]    cnt;
  mdu_op_e                 op_q;
  logic [XLEN-1:0]         opnd;
  logic [XLEN-1:0]         rem;
  logic [XLEN-1:0]         rem_nxt;
  logic [2*XLEN-1:0]       acc;
  logic [2*XLEN-1:0]       acc_nxt;
  logic                    neg_q;     // negate the product/quotient in FIX
  logic                    neg_r;     // give the remainder the dividend's sign
  logic                    div_zero;
  logic                    ovf;
  logic [XLEN-1:0]         resp_data_q;

  logic                    abort;
  logic                    accept;
  mdu_op_e                 req_op_e;
  logic                    is_div_in;
  logic                    signed1_in, signed2_in;
  logic                    sgn1_in, sgn2_in;
  logic [XLEN-1:0]         mag1_in, mag2_in;
  logic                    dz_in, ovf_in, fast_in;

  logic [2*XLEN-1:0]       prod;
  logic [XLEN-1:0]         quo;
  logic [XLEN-1:0]         remf;
  logic [XLEN-1:0]         result;

`ifdef FB_MDU_FLUSH_EN
  assign abort = flush;
`else
  assign abort = 1'b0;
`endif

  assign bus.req_ready  = (state == FB_MDU_IDLE);
  assign bus.resp_valid = (state == FB_MDU_DONE);
  assign bus.resp_data  = resp_data_q;
  assign busy           = (state != FB_MDU_IDLE);

  // A flush edge takes priority, so nothing is accepted at that edge.
  assign accept = bus.req_valid & bus.req_ready & ~abort;

  // --------------------------------------------------------------------------
  // Request decode. This is used only at the acceptance edge.
  // --------------------------------------------------------------------------
  assign req_op_e = mdu_op_e'(bus.req_op);

  always_comb begin
    is_div_in  = bus.req_op[2];
    signed1_in = (req_op_e == FB_MDU_MULH) || (req_op_e == FB_MDU_MULHSU) ||
                 (req_op_e == FB_MDU_DIV)  || (req_op_e == FB_MDU_REM);
    signed2_in = (req_op_e == FB_MDU_MULH) || (req_op_e == FB_MDU_DIV) ||
                 (req_op_e == FB_MDU_REM);
    sgn1_in    = signed1_in & bus.op1[XLEN-1];
    sgn2_in    = signed2_in & bus.op2[XLEN-1];
    mag1_in    = neg_if(sgn1_in, bus.op1);
    mag2_in    = neg_if(sgn2_in, bus.op2);
    dz_in      = is_div_in & (bus.op2 == '0);
    // DIV and REM are the signed divides, and both have funct3[0] == 0.
    ovf_in     = is_div_in & ~bus.req_op[0] &
                 (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op2 == '1);
    fast_in    = dz_in | ovf_in;
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FB_MDU_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FB_MDU_IDLE: if (accept) state_nxt = fast_in ? FB_MDU_FIX : FB_MDU_CALC;
      FB_MDU_CALC: if (cnt == MDU_CNT_W'(STEPS-1)) state_nxt = FB_MDU_FIX;
      FB_MDU_FIX:  state_nxt = FB_MDU_DONE;
      FB_MDU_DONE: if (bus.resp_ready) state_nxt = FB_MDU_IDLE;
      default:     state_nxt = FB_MDU_IDLE;
    endcase
    if (abort) state_nxt = FB_MDU_IDLE;
  end

  // --------------------------------------------------------------------------
  // Iteration step
  // --------------------------------------------------------------------------
  fb_mdu_step u_step (
    .is_div  (op_q[2]),
    .acc     (acc),
    .rem     (rem),
    .opnd    (opnd),
    .acc_nxt (acc_nxt),
    .rem_nxt (rem_nxt)
  );

  // --------------------------------------------------------------------------
  // Sign fix-up and result select. The value is registered in FIX.
  // --------------------------------------------------------------------------
  always_comb begin
    prod   = neg_q ? (~acc + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc;
    quo    = neg_if(neg_q, acc[XLEN-1:0]);
    remf   = neg_if(neg_r, rem);
    result = '0;
    unique case (op_q)
      FB_MDU_MUL:    result = prod[XLEN-1:0];
      FB_MDU_MULH,
      FB_MDU_MULHSU,
      FB_MDU_MULHU:  result = prod[2*XLEN-1:XLEN];
      FB_MDU_DIV,
      FB_MDU_DIVU:   result = div_zero ? '1 :
                              ovf      ? {1'b1, {(XLEN-1){1'b0}}} : quo;
      // On divide-by-zero, acc[31:0] was loaded with the raw dividend.
      FB_MDU_REM,
      FB_MDU_REMU:   result = div_zero ? acc[XLEN-1:0] :
                              ovf      ? '0 : remf;
      default:       result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      op_q        <= FB_MDU_MUL;
      opnd        <= '0;
      acc         <= '0;
      rem         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_zero    <= 1'b0;
      ovf         <= 1'b0;
      resp_data_q <= '0;
    end else if (accept) begin
      cnt      <= '0;
      op_q     <= req_op_e;
      opnd     <= is_div_in ? mag2_in : mag1_in;
      acc      <= {{XLEN{1'b0}},
                   is_div_in ? (dz_in ? bus.op1 : mag1_in) : mag2_in};
      rem      <= '0;
      neg_q    <= sgn1_in ^ sgn2_in;
      neg_r    <= sgn1_in;
      div_zero <= dz_in;
      ovf      <= ovf_in;
    end else if (state == FB_MDU_CALC) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nxt;
      rem <= rem_nxt;
    end else if (state == FB_MDU_FIX) begin
      resp_data_q <= result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_mdu.sv
`default_nettype none
// ============================================================================
// Module : tb_fb_mdu
// Purpose: Self-checking bench for fb_mdu. Expected results are pushed to a
//          scoreboard queue when a request is driven. They are popped and
//          compared when the response handshake completes.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fb_mdu;
  import fb_mdu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef FB_MDU_FLUSH_EN
  logic flush = 1'b0;
`endif

  fb_mdu_if bus();

  fb_mdu dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef FB_MDU_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Independent reference model that uses 64-bit integer arithmetic.
  function automatic logic [31:0] ref_mdu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint     sa, sb, p;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  // The fast path goes acceptance -> FIX -> DONE. resp_valid is therefore
  // seen one edge after the acceptance edge, which is the second edge when
  // the acceptance edge is counted. Normal ops take 32 CALC edges plus FIX.
  function automatic int exp_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 &&
                             b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Drive one request and wait for its response. Then hold resp_ready low
  // for 'hold' cycles before taking the result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int hold);
    int          lat;
    bit          got;
    logic [31:0] e;
    string       nm;
    nm = $sformatf("op%0d(%08h,%08h)", op, a, b);
    @(negedge clk);
    for (int i = 0; i < 100 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) begin
      check({nm, " req_ready timeout"}, 32'(bus.req_ready), 32'd1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.op1       = a;
    bus.op2       = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.op1       = $urandom;
    bus.op2       = $urandom;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
    if (!got) begin
      void'(exp_q.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check({nm, " hold data"}, bus.resp_data, exp_q[0]);
      check({nm, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
      check({nm, " hold busy"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.resp_ready = 1'b1;
    check({nm, " req_ready in handshake"}, 32'(bus.req_ready), 32'd0);
    e = exp_q.pop_front();
    check({nm, " data"}, bus.resp_data, e);
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    check({nm, " resp_valid after"}, 32'(bus.resp_valid), 32'd0);
    check({nm, " req_ready after"}, 32'(bus.req_ready), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[] = '{
    '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
    '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003},
    '{3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001},
    '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
    '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{3'd5, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF},
    '{3'd7, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009},
    '{3'd4, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          seen;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.op1        = '0;
    bus.op2        = '0;
    bus.resp_ready = 1'b0;

    // Reset is asserted from time 0, away from any clock edge.
    #12;
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_data", bus.resp_data, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset req_ready", 32'(bus.req_ready), 32'd1);

    // Directed vectors. The first one also exercises the DONE hold.
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, (i == 0) ? 5 : 0);

    // Random back-to-back traffic against the reference model. Small
    // divisors make the divide results non-trivial.
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run_op(rop, ra, rb, ref_mdu(rop, ra, rb), 0);
    end

    // Asynchronous reset in the middle of CALC, with counter == 10.
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd1;
    bus.op1       = 32'h1234_5678;
    bus.op2       = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("async rst resp_data", bus.resp_data, 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 0);

`ifdef FB_MDU_FLUSH_EN
    // Flush at counter == 10: the unit must go to IDLE with no response.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.op1       = 32'd3;
    bus.op2       = 32'd5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush req_ready", 32'(bus.req_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid) seen++;
    end
    check("flush no response", 32'(seen), 32'd0);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 0);
`endif

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
